// File: rtl/ddr_arb_pkg.sv
// Shared parameters, FSM state encoding and port indices for the DDR arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ddr_arb_pkg;

   localparam int ADDR_W_DEF = 27;
   localparam int LINE_W_DEF = 128;

   // 2-bit FSM encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_RD = 2'd1;
   localparam logic [1:0] ST_WAIT_WR = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   // requester port indices
   localparam logic PORT_I = 1'b0;   // instruction cache
   localparam logic PORT_D = 1'b1;   // data cache

endpackage

// File: rtl/ddr_arb_slot.sv
// Single-entry request slot for one requester port of the DDR arbiter.
// Latency: a pulse on an empty slot is held from the next edge on.
// Backpressure: pulses while the slot is occupied are dropped and flagged on err_o.
module ddr_arb_slot
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic              clr_i,
   output logic              vld_o,
   output logic              is_wr_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [LINE_W-1:0] data_o,
   output logic              err_o
);

   logic              vld_q, vld_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d;
   logic              req;

   assign req   = rd_en_i | wr_en_i;
   // an occupied slot (pending or being served) drops new pulses; a
   // simultaneous read+write is also a violation, and the write wins
   assign err_o = (req & vld_q) | (rd_en_i & wr_en_i);

   // next-state: the slot stays valid until the arbiter delivers the fin
   always_comb begin
      vld_d  = vld_q;
      wr_d   = wr_q;
      addr_d = addr_q;
      data_d = data_q;
      if (clr_i) begin
         vld_d  = 1'b0;
         wr_d   = 1'b0;
         addr_d = '0;
         data_d = '0;
      end else if (req && !vld_q) begin
         vld_d  = 1'b1;
         wr_d   = wr_en_i;
         addr_d = wr_en_i ? wr_addr_i : rd_addr_i;
         data_d = wr_en_i ? wr_data_i : '0;
      end
   end

   // slot registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign vld_o   = vld_q;
   assign is_wr_o = wr_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ddr_arbiter.sv
// Two-port (icache/dcache) round-robin arbiter in front of a single DDR command port.
// Latency: request pulse t -> DDR command t+2; DDR fin f -> requester fin f+1.
// Backpressure: one slot per port; one DDR command outstanding; extra pulses dropped + proto_err.
module ddr_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_rd_en,
   input  logic [ADDR_W-1:0] p0_rd_addr,
   input  logic              p0_wr_en,
   input  logic [ADDR_W-1:0] p0_wr_addr,
   input  logic [LINE_W-1:0] p0_wr_data,
   output logic              p0_rd_fin,
   output logic [LINE_W-1:0] p0_rd_data,
   output logic              p0_wr_fin,
   output logic              p0_busy,
   input  logic              p1_rd_en,
   input  logic [ADDR_W-1:0] p1_rd_addr,
   input  logic              p1_wr_en,
   input  logic [ADDR_W-1:0] p1_wr_addr,
   input  logic [LINE_W-1:0] p1_wr_data,
   output logic              p1_rd_fin,
   output logic [LINE_W-1:0] p1_rd_data,
   output logic              p1_wr_fin,
   output logic              p1_busy,
   output logic              ddr_rd_en,
   output logic [ADDR_W-1:0] ddr_rd_addr,
   input  logic              ddr_rd_fin,
   input  logic [LINE_W-1:0] ddr_rd_data,
   output logic              ddr_wr_en,
   output logic [ADDR_W-1:0] ddr_wr_addr,
   output logic [LINE_W-1:0] ddr_wr_data,
   input  logic              ddr_wr_fin,
   output logic              proto_err
);

   logic [1:0]        slot_vld, slot_wr, slot_err, slot_clr;
   logic [ADDR_W-1:0] slot_addr [2];
   logic [LINE_W-1:0] slot_data [2];

   logic [1:0]        state_q, state_d;
   logic              ptr_q, ptr_d, gnt_q, gnt_d;
   logic              ddr_rd_en_q, ddr_rd_en_d, ddr_wr_en_q, ddr_wr_en_d;
   logic [ADDR_W-1:0] ddr_rd_addr_q, ddr_rd_addr_d, ddr_wr_addr_q, ddr_wr_addr_d;
   logic [LINE_W-1:0] ddr_wr_data_q, ddr_wr_data_d;
   logic [1:0]        rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
   logic [LINE_W-1:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
   logic              proto_err_q, proto_err_d;

   logic              done, stray_fin, sel;

   ddr_arb_slot #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_slot0 (
      .clk(clk), .rst(rst),
      .rd_en_i(p0_rd_en), .rd_addr_i(p0_rd_addr),
      .wr_en_i(p0_wr_en), .wr_addr_i(p0_wr_addr), .wr_data_i(p0_wr_data),
      .clr_i(slot_clr[0]),
      .vld_o(slot_vld[0]), .is_wr_o(slot_wr[0]), .addr_o(slot_addr[0]),
      .data_o(slot_data[0]), .err_o(slot_err[0])
   );

   ddr_arb_slot #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_slot1 (
      .clk(clk), .rst(rst),
      .rd_en_i(p1_rd_en), .rd_addr_i(p1_rd_addr),
      .wr_en_i(p1_wr_en), .wr_addr_i(p1_wr_addr), .wr_data_i(p1_wr_data),
      .clr_i(slot_clr[1]),
      .vld_o(slot_vld[1]), .is_wr_o(slot_wr[1]), .addr_o(slot_addr[1]),
      .data_o(slot_data[1]), .err_o(slot_err[1])
   );

   assign done      = ((state_q == ST_WAIT_RD) && ddr_rd_fin) ||
                      ((state_q == ST_WAIT_WR) && ddr_wr_fin);
   // any fin outside the matching WAIT state is a protocol violation
   assign stray_fin = (ddr_rd_fin && (state_q != ST_WAIT_RD)) ||
                      (ddr_wr_fin && (state_q != ST_WAIT_WR));
   assign slot_clr[0] = done && (gnt_q == PORT_I);
   assign slot_clr[1] = done && (gnt_q == PORT_D);
   // round-robin: the pointer only matters when both slots compete
   assign sel = (slot_vld[0] && slot_vld[1]) ? ptr_q : slot_vld[1];

   // arbitration FSM, DDR command generation and response routing
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      ddr_rd_en_d   = 1'b0;
      ddr_wr_en_d   = 1'b0;
      ddr_rd_addr_d = ddr_rd_addr_q;
      ddr_wr_addr_d = ddr_wr_addr_q;
      ddr_wr_data_d = ddr_wr_data_q;
      rd_fin_d      = '0;
      wr_fin_d      = '0;
      rd_data0_d    = '0;
      rd_data1_d    = '0;
      proto_err_d   = proto_err_q | slot_err[0] | slot_err[1] | stray_fin;
      case (state_q)
         ST_IDLE: begin
            if (|slot_vld) begin
               gnt_d = sel;
               ptr_d = ~sel;
               if (slot_wr[sel]) begin
                  ddr_wr_en_d   = 1'b1;
                  ddr_wr_addr_d = slot_addr[sel];
                  ddr_wr_data_d = slot_data[sel];
                  state_d       = ST_WAIT_WR;
               end else begin
                  ddr_rd_en_d   = 1'b1;
                  ddr_rd_addr_d = slot_addr[sel];
                  state_d       = ST_WAIT_RD;
               end
            end
         end
         ST_WAIT_RD: begin
            if (ddr_rd_fin) begin
               rd_fin_d[gnt_q] = 1'b1;
               if (gnt_q == PORT_D) rd_data1_d = ddr_rd_data;
               else                 rd_data0_d = ddr_rd_data;
               ddr_rd_addr_d = '0;
               state_d       = ST_RESP;
            end
         end
         ST_WAIT_WR: begin
            if (ddr_wr_fin) begin
               wr_fin_d[gnt_q] = 1'b1;
               ddr_wr_addr_d   = '0;
               ddr_wr_data_d   = '0;
               state_d         = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;   // RESP: fin/data fall back to 0
      endcase
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= PORT_I;
         gnt_q         <= PORT_I;
         ddr_rd_en_q   <= 1'b0;
         ddr_wr_en_q   <= 1'b0;
         ddr_rd_addr_q <= '0;
         ddr_wr_addr_q <= '0;
         ddr_wr_data_q <= '0;
         rd_fin_q      <= '0;
         wr_fin_q      <= '0;
         rd_data0_q    <= '0;
         rd_data1_q    <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         ddr_rd_en_q   <= ddr_rd_en_d;
         ddr_wr_en_q   <= ddr_wr_en_d;
         ddr_rd_addr_q <= ddr_rd_addr_d;
         ddr_wr_addr_q <= ddr_wr_addr_d;
         ddr_wr_data_q <= ddr_wr_data_d;
         rd_fin_q      <= rd_fin_d;
         wr_fin_q      <= wr_fin_d;
         rd_data0_q    <= rd_data0_d;
         rd_data1_q    <= rd_data1_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign ddr_rd_en   = ddr_rd_en_q;
   assign ddr_rd_addr = ddr_rd_addr_q;
   assign ddr_wr_en   = ddr_wr_en_q;
   assign ddr_wr_addr = ddr_wr_addr_q;
   assign ddr_wr_data = ddr_wr_data_q;
   assign p0_rd_fin   = rd_fin_q[0];
   assign p1_rd_fin   = rd_fin_q[1];
   assign p0_wr_fin   = wr_fin_q[0];
   assign p1_wr_fin   = wr_fin_q[1];
   assign p0_rd_data  = rd_data0_q;
   assign p1_rd_data  = rd_data1_q;
   assign p0_busy     = slot_vld[0];
   assign p1_busy     = slot_vld[1];
   assign proto_err   = proto_err_q;

endmodule
